sdp_ram_be_init: RTL

Single-clock simple-dual-port RAM, one write port and one read port. It is the next generation of the team's two-clock dual-port memory. Adds per-byte write enables, a selectable read latency (1 or 2) with a read-valid strobe, and defined same-address read/write collision behaviour. After every reset it runs a hardware initialisation sweep, so contents are deterministic. Used as packet/descriptor storage inside the switch datapath where both sides share one clock.

---
 rtl/sdp_ram_pkg.sv | 39 +++
 rtl/sdp_ram_be_init_if.sv | 41 ++++
 rtl/sdp_ram_init_seq.sv | 58 +++++
 rtl/sdp_ram_be_init.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// -----------------------------------------------------------------------------
// sdp_ram_pkg
// Shared types and helpers for the sdp_ram_be_init memory.
//   ram_state_t : sweep sequencer states (ST_INIT while the array is being
//                 cleared, ST_READY for normal operation)
//   byte_merge  : lane-wise merge of a new word into an old word, used both
//                 for the array write and for the write-first collision bypass
// -----------------------------------------------------------------------------
package sdp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  // Widest word the merge helper handles; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int MAX_DATA_W = 256;

  // Bit j belongs to lane j/byte_w; take the new bit where that lane is
  // enabled, the old bit otherwise. Lanes beyond the caller's NUM_BYTES have
  // zero enables, so the (unused) upper bits simply keep the old value.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_DATA_W-1:0] be,
    input int                    byte_w
  );
    logic [MAX_DATA_W-1:0] res;
    logic [7:0]            lane;
    res = old_word;
    for (int j = 0; j < MAX_DATA_W; j++) begin
      lane = 8'(j / byte_w);
      if (be[lane]) res[j] = new_word[j];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdp_ram_be_init_if.sv
// -----------------------------------------------------------------------------
// sdp_ram_be_init_if
// Write port, read port and status of the single-clock simple-dual-port RAM.
//   master : drives wen/waddr/wbe/wdata and ren/raddr; observes
//            rdata/rvalid/init_done
//   slave  : the memory side
//
// Handshake: there is no back-pressure. A request (wen or ren) is accepted at
// a rising edge exactly when init_done is high at that edge; requests while
// init_done is low are dropped. Every accepted read produces exactly one
// cycle of rvalid, READ_LATENCY cycles after its edge, in request order;
// rdata holds its last value while rvalid is low.
// -----------------------------------------------------------------------------
interface sdp_ram_be_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYTE_WIDTH = 8
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [NUM_BYTES-1:0]  wbe;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  init_done;

  modport master (
    output wen, waddr, wbe, wdata, ren, raddr,
    input  rdata, rvalid, init_done
  );

  modport slave (
    input  wen, waddr, wbe, wdata, ren, raddr,
    output rdata, rvalid, init_done
  );

endinterface

// File: rtl/sdp_ram_init_seq.sv
// -----------------------------------------------------------------------------
// sdp_ram_init_seq
// INIT/READY sequencer. After reset it walks every address once, asserting
// init_we_o with init_addr_o = 0 .. DEPTH-1, then parks in READY.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   init_we_o     : write INIT_VALUE to init_addr_o at this edge
//   init_addr_o   : sweep address
//   init_done_o   : high in READY (user accesses accepted)
//   state_o       : current state, for observation
// -----------------------------------------------------------------------------
module sdp_ram_init_seq
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  init_done_o,
  output ram_state_t            state_o
);

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_o = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        // The write of the last address completes the sweep.
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  assign init_addr_o = cnt_q;
  assign init_done_o = (state_q == ST_READY);
  assign state_o     = state_q;

endmodule

// File: rtl/sdp_ram_be_init.sv
// -----------------------------------------------------------------------------
// sdp_ram_be_init
// Single-clock simple-dual-port RAM with per-byte write enables, read latency
// of 1 or 2 with a read-valid strobe, defined same-address collision result
// and a hardware clearing sweep after every reset.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : write/read port and status (sdp_ram_be_init_if.slave)
//   state_o  : sequencer state, for observation
// -----------------------------------------------------------------------------
module sdp_ram_be_init
  import sdp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_FIRST  = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                clk,
  input  logic                rst,
  sdp_ram_be_init_if.slave    bus,
  output ram_state_t          state_o
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  if (NUM_BYTES * BYTE_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("sdp_ram_be_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sdp_ram_be_init: READ_LATENCY must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Sweep sequencer
  // ---------------------------------------------------------------------------
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  ready;

  sdp_ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk         (clk),
    .rst         (rst),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_done_o (ready),
    .state_o     (state_o)
  );

  assign bus.init_done = ready;

  // ---------------------------------------------------------------------------
  // Array and write port
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  // A reset edge accepts nothing, even if the sequencer is still in READY.
  assign wr_fire = ready && !rst && bus.wen;
  assign rd_fire = ready && !rst && bus.ren;

  assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_W'(ram_q[bus.waddr]),
                                            MAX_DATA_W'(bus.wdata),
                                            MAX_DATA_W'(bus.wbe),
                                            BYTE_WIDTH));

  // The sequencer only asserts init_we in INIT, where user writes are not
  // accepted, so the two write sources never compete.
  always_ff @(posedge clk) begin
    if (init_we) begin
      ram_q[init_addr] <= INIT_VALUE;
    end else if (wr_fire) begin
      ram_q[bus.waddr] <= wr_merged;
    end
  end

  // Same-edge same-address read sees the merged word in write-first mode and
  // the pre-write contents otherwise.
  always_comb begin
    rd_word = ram_q[bus.raddr];
    if (WRITE_FIRST != 0 && wr_fire && bus.waddr == bus.raddr) rd_word = wr_merged;
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 1 samples the array at the ren edge; stage 2 (latency
  // 2 only) just re-registers it, so later writes cannot affect it.
  // ---------------------------------------------------------------------------
  logic                  s1_v_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_v_q <= rd_fire;
      if (rd_fire) s1_data_q <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_v_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v_q    <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_data_q <= s1_data_q;
      end
    end

    assign bus.rdata  = s2_data_q;
    assign bus.rvalid = s2_v_q;
  end else begin : g_lat1
    assign bus.rdata  = s1_data_q;
    assign bus.rvalid = s1_v_q;
  end

endmodule
